// File: rtl/universal_reg.sv
// Universal shift/rotate/load register with a multi-step command sequencer.
// Optional even-parity output enabled by defining UNIVERSAL_REG_PARITY_EN.
module universal_reg #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   d,
  input  logic               sin,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               start,
  output logic [WIDTH-1:0]   q,
  output logic               sout,
  output logic               busy,
  output logic               done,
  output logic               parity
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] OP_HOLD = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_SHL  = 3'b010;
  localparam logic [2:0] OP_SHR  = 3'b011;
  localparam logic [2:0] OP_ROTL = 3'b100;
  localparam logic [2:0] OP_ROTR = 3'b101;
  localparam logic [2:0] OP_CLR  = 3'b110;
  localparam logic [2:0] OP_ASR  = 3'b111;

  state_t             state_r;
  logic [SHAMT_W-1:0] cnt_r;
  logic [2:0]         op_l_r;
  logic [WIDTH-1:0]   q_r;
  logic               sout_r;
  logic               busy_r;
  logic               done_r;

  logic [2:0]         step_op_s;
  logic [WIDTH-1:0]   q_nxt_s;
  logic               sout_nxt_s;

  // Returns {sout, q} after one step of operation o.
  function automatic logic [WIDTH:0] step_f(
    input logic [2:0]       o,
    input logic [WIDTH-1:0] v,
    input logic [WIDTH-1:0] dv,
    input logic             s,
    input logic             so
  );
    case (o)
      OP_HOLD: step_f = {so, v};
      OP_LOAD: step_f = {so, dv};
      OP_SHL:  step_f = {v[WIDTH-1], v[WIDTH-2:0], s};
      OP_SHR:  step_f = {v[0], s, v[WIDTH-1:1]};
      OP_ROTL: step_f = {v[WIDTH-1], v[WIDTH-2:0], v[WIDTH-1]};
      OP_ROTR: step_f = {v[0], v[0], v[WIDTH-1:1]};
      OP_CLR:  step_f = {so, {WIDTH{1'b0}}};
      OP_ASR:  step_f = {v[0], v[WIDTH-1], v[WIDTH-1:1]};
      default: step_f = {so, v};
    endcase
  endfunction

  // Only the shift/rotate family may run as a multi-step command.
  function automatic logic is_multi_f(input logic [2:0] o);
    case (o)
      OP_SHL, OP_SHR, OP_ROTL, OP_ROTR, OP_ASR: is_multi_f = 1'b1;
      default:                                  is_multi_f = 1'b0;
    endcase
  endfunction

  // Next-step datapath: latched op while running, live op otherwise.
  always_comb begin
    step_op_s = op;
    if (state_r == RUN) begin
      step_op_s = op_l_r;
    end else begin
      step_op_s = op;
    end
    {sout_nxt_s, q_nxt_s} = step_f(step_op_s, q_r, d, sin, sout_r);
  end

  // Sequencer, register contents and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= {SHAMT_W{1'b0}};
      op_l_r  <= OP_HOLD;
      q_r     <= {WIDTH{1'b0}};
      sout_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else if (en) begin
      case (state_r)
        IDLE, DONE: begin
          if (start && is_multi_f(op)) begin
            op_l_r <= op;
            cnt_r  <= shamt;
            if (shamt != {SHAMT_W{1'b0}}) begin
              state_r <= RUN;
              busy_r  <= 1'b1;
              done_r  <= 1'b0;
            end else begin
              state_r <= DONE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end
          end else begin
            q_r     <= q_nxt_s;
            sout_r  <= sout_nxt_s;
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
          end
        end
        RUN: begin
          q_r    <= q_nxt_s;
          sout_r <= sout_nxt_s;
          cnt_r  <= cnt_r - SHAMT_W'(1);
          // Last step when the counter is about to reach zero.
          if (cnt_r == SHAMT_W'(1)) begin
            state_r <= DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end else begin
            state_r <= RUN;
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign q    = q_r;
  assign sout = sout_r;
  assign busy = busy_r;
  assign done = done_r;

`ifdef UNIVERSAL_REG_PARITY_EN
  function automatic logic parity_f(input logic [WIDTH-1:0] v);
    parity_f = ^v;
  endfunction

  assign parity = parity_f(q_r);
`else
  assign parity = 1'b0;
`endif

endmodule

// File: tb/tb_universal_reg.sv
// Scoreboard bench for universal_reg (WIDTH=8, SHAMT_W=3): a behavioural
// model pushes expected outputs per driven cycle; they are popped after the edge.
module tb_universal_reg;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [2:0] op = 3'b000;
  logic [7:0] d = 8'h00;
  logic       sin = 1'b0;
  logic [2:0] shamt = 3'b000;
  logic       start = 1'b0;
  logic [7:0] q;
  logic       sout, busy, done, parity;

  universal_reg #(.WIDTH(8), .SHAMT_W(3)) dut (
    .clk(clk), .rst(rst), .en(en), .op(op), .d(d), .sin(sin),
    .shamt(shamt), .start(start), .q(q), .sout(sout), .busy(busy),
    .done(done), .parity(parity)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] q;
    logic       sout;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t sb[$];
  int   nchk = 0;
  int   nerr = 0;

  // Model state: mst 0=idle, 1=run, 2=done
  logic [7:0] mq = 8'h00;
  logic       ms = 1'b0;
  int         mst = 0;
  int         mcnt = 0;
  logic [2:0] mop = 3'b000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nchk++;
    if (obs !== expv) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, expv, $time);
    end
  endtask

  function automatic logic [8:0] mstep(input logic [2:0] o, input logic [7:0] v,
                                       input logic [7:0] dd, input logic s, input logic so);
    logic [7:0] r;
    case (o)
      3'd1: return {so, dd};
      3'd2: begin r = (v << 1) | {7'd0, s};        return {v[7], r}; end
      3'd3: begin r = (v >> 1) | {s, 7'd0};        return {v[0], r}; end
      3'd4: begin r = (v << 1) | (v >> 7);         return {v[7], r}; end
      3'd5: begin r = (v >> 1) | (v << 7);         return {v[0], r}; end
      3'd6: return {so, 8'h00};
      3'd7: begin r = 8'($signed(v) >>> 1);        return {v[0], r}; end
      default: return {so, v};
    endcase
  endfunction

  task automatic cyc(input logic r, input logic e, input logic st, input logic [2:0] o,
                     input logic [7:0] dd, input logic s, input logic [2:0] sh);
    exp_t x;
    exp_t y;
    logic exp_par;
    rst = r; en = e; start = st; op = o; d = dd; sin = s; shamt = sh;
    if (r) begin
      mq = 8'h00; ms = 1'b0; mst = 0; mcnt = 0;
    end else if (e) begin
      if (mst == 1) begin
        {ms, mq} = mstep(mop, mq, dd, s, ms);
        mcnt--;
        if (mcnt == 0) mst = 2;
      end else if (st && (o == 3'd2 || o == 3'd3 || o == 3'd4 || o == 3'd5 || o == 3'd7)) begin
        mop = o; mcnt = int'(sh);
        mst = (sh != 3'd0) ? 1 : 2;
      end else begin
        {ms, mq} = mstep(o, mq, dd, s, ms);
        mst = 0;
      end
    end
    x.q = mq; x.sout = ms; x.busy = (mst == 1); x.done = (mst == 2);
    sb.push_back(x);
    @(posedge clk);
    #1;
    y = sb.pop_front();
    chk("q", 32'(q), 32'(y.q));
    chk("sout", 32'(sout), 32'(y.sout));
    chk("busy", 32'(busy), 32'(y.busy));
    chk("done", 32'(done), 32'(y.done));
`ifdef UNIVERSAL_REG_PARITY_EN
    exp_par = ^y.q;
`else
    exp_par = 1'b0;
`endif
    chk("parity", 32'(parity), 32'(exp_par));
  endtask

  // Cycle while running with junk on the inputs that must be ignored.
  task automatic junk(input logic e);
    cyc(1'b0, e, $urandom_range(0, 1), 3'($urandom), 8'($urandom), $urandom_range(0, 1), 3'($urandom));
  endtask

  initial begin
    cyc(1'b1, 1'b1, 1'b1, 3'd4, 8'hFF, 1'b1, 3'd3);
    chk("rst_q", 32'(q), 32'h00);
    chk("rst_busy", 32'(busy), 32'h0);

    cyc(1'b0, 1'b1, 1'b0, 3'd1, 8'hA5, 1'b0, 3'd0);
    chk("load_a5", 32'(q), 32'hA5);

    // rotl by 3 of 0x81
    cyc(1'b0, 1'b1, 1'b0, 3'd1, 8'h81, 1'b0, 3'd0);
    cyc(1'b0, 1'b1, 1'b1, 3'd4, 8'h00, 1'b0, 3'd3);
    chk("rotl_start_q", 32'(q), 32'h81);
    chk("rotl_busy0", 32'(busy), 32'h1);
    junk(1'b1); junk(1'b1);
    chk("rotl_busy2", 32'(busy), 32'h1);
    junk(1'b1);
    chk("rotl_q", 32'(q), 32'h0C);
    chk("rotl_sout", 32'(sout), 32'h0);
    chk("rotl_done", 32'(done), 32'h1);
    cyc(1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0);
    chk("rotl_done_off", 32'(done), 32'h0);

    // asr by 7 of 0x80, then a zero-length command
    cyc(1'b0, 1'b1, 1'b0, 3'd1, 8'h80, 1'b0, 3'd0);
    cyc(1'b0, 1'b1, 1'b1, 3'd7, 8'h00, 1'b0, 3'd7);
    for (int i = 0; i < 7; i++) junk(1'b1);
    chk("asr_q", 32'(q), 32'hFF);
    chk("asr_done", 32'(done), 32'h1);
    cyc(1'b0, 1'b1, 1'b1, 3'd2, 8'h00, 1'b0, 3'd0);
    chk("zero_done", 32'(done), 32'h1);
    chk("zero_q", 32'(q), 32'hFF);
    chk("zero_busy", 32'(busy), 32'h0);

    // single steps with both sin values, plus start with non-shift ops
    cyc(1'b0, 1'b1, 1'b0, 3'd1, 8'h5A, 1'b0, 3'd0);
    cyc(1'b0, 1'b1, 1'b0, 3'd2, 8'h00, 1'b1, 3'd0);
    chk("shl_q", 32'(q), 32'hB5);
    cyc(1'b0, 1'b1, 1'b0, 3'd3, 8'h00, 1'b1, 3'd0);
    chk("shr_q", 32'(q), 32'hDA);
    cyc(1'b0, 1'b1, 1'b0, 3'd5, 8'h00, 1'b0, 3'd0);
    cyc(1'b0, 1'b1, 1'b1, 3'd1, 8'h07, 1'b0, 3'd5);
    chk("start_load_busy", 32'(busy), 32'h0);
    cyc(1'b0, 1'b1, 1'b1, 3'd0, 8'h00, 1'b0, 3'd5);
    cyc(1'b0, 1'b1, 1'b1, 3'd6, 8'h00, 1'b0, 3'd5);
    chk("clear_q", 32'(q), 32'h00);

    // stall mid-run with en=0
    cyc(1'b0, 1'b1, 1'b0, 3'd1, 8'hC3, 1'b0, 3'd0);
    cyc(1'b0, 1'b1, 1'b1, 3'd5, 8'h00, 1'b0, 3'd4);
    junk(1'b1);
    junk(1'b0); junk(1'b0);
    chk("stall_busy", 32'(busy), 32'h1);
    for (int i = 0; i < 3; i++) junk(1'b1);
    chk("stall_q", 32'(q), 32'h3C);
    chk("stall_done", 32'(done), 32'h1);

    // reset mid-run aborts without done
    cyc(1'b0, 1'b1, 1'b1, 3'd2, 8'h00, 1'b1, 3'd6);
    junk(1'b1); junk(1'b1);
    cyc(1'b1, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0);
    chk("abort_q", 32'(q), 32'h00);
    chk("abort_busy", 32'(busy), 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0);
    chk("abort_no_done", 32'(done), 32'h0);

    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 80),
          ($urandom_range(0, 99) < 30), 3'($urandom), 8'($urandom),
          $urandom_range(0, 1), 3'($urandom));
    end

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
